// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Game-flow controller for a fixed-shooter arcade game. It
//               tracks game state (IDLE / PLAY / CLEAR / OVER), score, lives,
//               aliens left and wave number. It also paces the alien
//               formation from frame ticks and turns the fire button into
//               one-cycle bullet launch requests.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FRAME_LINE    vertical line whose px==0 marks the end of a frame
//   STEP_DIV_MIN  minimum number of frames between alien steps
//   ALIEN_COUNT   aliens per wave (1..63)
//   LIVES_INIT    lives per game (1..3)
//   CLEAR_FRAMES  pause length between waves, in frames
// Ports
//   iCLK           in   1   pixel-domain clock
//   iRST_N         in   1   synchronous active-low reset
//   iStart_N       in   1   start pushbutton, active-low, asynchronous
//   iFire_N        in   1   fire pushbutton, active-low, asynchronous
//   iPx / iPy      in  10   current pixel coordinates
//   iAlienHit      in   1   one-cycle pulse, one alien destroyed
//   iPlayerHit     in   1   one-cycle pulse, player ship hit
//   iAliensLanded  in   1   level, alien row reached the ground
//   iBulletBusy    in   1   player bullet in flight
//   oState         out  2   0 IDLE, 1 PLAY, 2 CLEAR, 3 OVER
//   oStepTick      out  1   one-cycle pulse, advance alien formation
//   oFireReq       out  1   one-cycle pulse, launch player bullet
//   oScore         out 16   score (saturating)
//   oLives         out  2   lives remaining
//   oAliensLeft    out  6   aliens alive in the current wave
//   oWave          out  4   wave number (saturating at 15)
// Build option
//   GAME_SEQ_AUTOFIRE_EN  when defined, a held fire button also fires each
//                         time the bullet in flight finishes
// ============================================================================
module game_sequencer #(
    parameter int FRAME_LINE   = 480,
    parameter int STEP_DIV_MIN = 2,
    parameter int ALIEN_COUNT  = 40,
    parameter int LIVES_INIT   = 3,
    parameter int CLEAR_FRAMES = 60
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iStart_N,
    input  logic        iFire_N,
    input  logic [9:0]  iPx,
    input  logic [9:0]  iPy,
    input  logic        iAlienHit,
    input  logic        iPlayerHit,
    input  logic        iAliensLanded,
    input  logic        iBulletBusy,
    output logic [1:0]  oState,
    output logic        oStepTick,
    output logic        oFireReq,
    output logic [15:0] oScore,
    output logic [1:0]  oLives,
    output logic [5:0]  oAliensLeft,
    output logic [3:0]  oWave
);

    // ------------------------------------------------------------------------
    // State encoding and sized constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PLAY  = 2'd1;
    localparam logic [1:0] c_ST_CLEAR = 2'd2;
    localparam logic [1:0] c_ST_OVER  = 2'd3;

    localparam logic [9:0]  c_FRAME_LINE   = 10'(FRAME_LINE);
    localparam logic [15:0] c_STEP_DIV_MIN = 16'(STEP_DIV_MIN);
    localparam logic [15:0] c_CLEAR_LAST   = 16'(CLEAR_FRAMES - 1);
    localparam logic [5:0]  c_ALIEN_COUNT  = 6'(ALIEN_COUNT);
    localparam logic [1:0]  c_LIVES_INIT   = 2'(LIVES_INIT);
    localparam logic [15:0] c_SCORE_STEP   = 16'd10;
    // Highest score that can still take a full increment without wrapping.
    localparam logic [15:0] c_SCORE_ROOM   = 16'hFFFF - c_SCORE_STEP;
    localparam logic [3:0]  c_WAVE_MAX     = 4'd15;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // Button synchronizers: meta -> sync -> prev. The extra "prev" stage gives
    // a clean falling-edge detect on the synchronized level. All stages reset
    // to 1, so the buttons read as released and no press appears after reset.
    logic        r_start_meta;
    logic        r_start_sync;
    logic        r_start_prev;
    logic        r_fire_meta;
    logic        r_fire_sync;
    logic        r_fire_prev;

    logic        r_at_frame_d;  // frame coordinate seen on the previous cycle
    logic [1:0]  r_state;
    logic [15:0] r_frame_cnt;   // step divider in PLAY, pause timer in CLEAR
    logic        r_step_tick;
    logic        r_fire_req;
    logic [15:0] r_score;
    logic [1:0]  r_lives;
    logic [5:0]  r_aliens;
    logic [3:0]  r_wave;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_start_press;
    logic        w_fire_press;
    logic        w_at_frame;
    logic        w_frame_tick;
    logic [15:0] w_step_div;
    logic [15:0] w_step_last;
    logic [5:0]  w_aliens_next;
    logic [15:0] w_score_next;
    logic [1:0]  w_lives_next;
    logic        w_fire_auto;
    logic        w_fire_trig;
    logic [3:0]  w_wave_next;

    assign w_start_press = r_start_prev & ~r_start_sync;
    assign w_fire_press  = r_fire_prev  & ~r_fire_sync;

    // The beam can dwell on the trigger coordinate for several cycles. Only
    // the first of those cycles counts as the frame tick.
    assign w_at_frame   = (iPx == 10'd0) && (iPy == c_FRAME_LINE);
    assign w_frame_tick = w_at_frame & ~r_at_frame_d;

    // The formation speeds up as it thins out.
    assign w_step_div  = c_STEP_DIV_MIN + {11'd0, r_aliens[5:1]};
    assign w_step_last = w_step_div - 16'd1;

    assign w_wave_next = (r_wave == c_WAVE_MAX) ? r_wave : r_wave + 4'd1;

`ifdef GAME_SEQ_AUTOFIRE_EN
    // With the button held, fire again the moment the previous bullet ends.
    logic r_busy_d;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_busy_d <= 1'b0;
        end else begin
            r_busy_d <= iBulletBusy;
        end
    end

    assign w_fire_auto = ~r_fire_sync & r_busy_d & ~iBulletBusy;
`else
    assign w_fire_auto = 1'b0;
`endif

    // A press while the bullet is in flight is dropped, not queued.
    assign w_fire_trig = (w_fire_press & ~iBulletBusy) | w_fire_auto;

    // Hit bookkeeping. These values are committed only in PLAY. The exit
    // decision looks at these post-update values, so two hits in the same
    // cycle are both applied before the exit is chosen.
    always_comb begin
        w_aliens_next = r_aliens;
        w_score_next  = r_score;
        w_lives_next  = r_lives;

        if (iAlienHit) begin
            if (r_aliens != 6'd0) begin
                w_aliens_next = r_aliens - 6'd1;
            end
            if (r_score > c_SCORE_ROOM) begin
                w_score_next = 16'hFFFF;
            end else begin
                w_score_next = r_score + c_SCORE_STEP;
            end
        end

        // Landing ends the game outright, regardless of ship hits.
        if (iAliensLanded) begin
            w_lives_next = 2'd0;
        end else if (iPlayerHit && (r_lives != 2'd0)) begin
            w_lives_next = r_lives - 2'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Synchronizers and frame-edge history
    // ------------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_start_meta <= 1'b1;
            r_start_sync <= 1'b1;
            r_start_prev <= 1'b1;
            r_fire_meta  <= 1'b1;
            r_fire_sync  <= 1'b1;
            r_fire_prev  <= 1'b1;
            r_at_frame_d <= 1'b0;
        end else begin
            r_start_meta <= iStart_N;
            r_start_sync <= r_start_meta;
            r_start_prev <= r_start_sync;
            r_fire_meta  <= iFire_N;
            r_fire_sync  <= r_fire_meta;
            r_fire_prev  <= r_fire_sync;
            r_at_frame_d <= w_at_frame;
        end
    end

    // ------------------------------------------------------------------------
    // Game state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state     <= c_ST_IDLE;
            r_frame_cnt <= 16'd0;
            r_step_tick <= 1'b0;
            r_fire_req  <= 1'b0;
            r_score     <= 16'd0;
            r_lives     <= c_LIVES_INIT;
            r_aliens    <= c_ALIEN_COUNT;
            r_wave      <= 4'd1;
        end else begin
            // Pulses are high for one cycle unless re-armed below.
            r_step_tick <= 1'b0;
            r_fire_req  <= 1'b0;

            case (r_state)
                c_ST_IDLE, c_ST_OVER: begin
                    // OVER keeps the final score and lives on display until
                    // a new game is started.
                    if (w_start_press) begin
                        r_state     <= c_ST_PLAY;
                        r_frame_cnt <= 16'd0;
                        r_score     <= 16'd0;
                        r_lives     <= c_LIVES_INIT;
                        r_aliens    <= c_ALIEN_COUNT;
                        r_wave      <= 4'd1;
                    end
                end

                c_ST_PLAY: begin
                    r_score  <= w_score_next;
                    r_lives  <= w_lives_next;
                    r_aliens <= w_aliens_next;

                    // OVER is checked first, so it wins when both exits
                    // qualify. Pulses are suppressed on the exit cycle so
                    // that none can appear outside PLAY.
                    if (w_lives_next == 2'd0) begin
                        r_state     <= c_ST_OVER;
                        r_frame_cnt <= 16'd0;
                    end else if (w_aliens_next == 6'd0) begin
                        r_state     <= c_ST_CLEAR;
                        r_frame_cnt <= 16'd0;
                    end else begin
                        r_fire_req <= w_fire_trig;
                        if (w_frame_tick) begin
                            // A >= test handles a divider that shrinks below
                            // the running count after hits.
                            if (r_frame_cnt >= w_step_last) begin
                                r_frame_cnt <= 16'd0;
                                r_step_tick <= 1'b1;
                            end else begin
                                r_frame_cnt <= r_frame_cnt + 16'd1;
                            end
                        end
                    end
                end

                c_ST_CLEAR: begin
                    if (w_frame_tick) begin
                        if (r_frame_cnt >= c_CLEAR_LAST) begin
                            r_state     <= c_ST_PLAY;
                            r_frame_cnt <= 16'd0;
                            r_aliens    <= c_ALIEN_COUNT;
                            r_wave      <= w_wave_next;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------------
    assign oState      = r_state;
    assign oStepTick   = r_step_tick;
    assign oFireReq    = r_fire_req;
    assign oScore      = r_score;
    assign oLives      = r_lives;
    assign oAliensLeft = r_aliens;
    assign oWave       = r_wave;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_sequencer
// Description : Self-checking bench for game_sequencer (default parameters).
//               It uses a table of hit vectors plus hand-written sequences
//               for start, pacing, fire, wave clear, simultaneous exit and
//               mid-game reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        iStart_N;
    logic        iFire_N;
    logic [9:0]  iPx;
    logic [9:0]  iPy;
    logic        iAlienHit;
    logic        iPlayerHit;
    logic        iAliensLanded;
    logic        iBulletBusy;
    logic [1:0]  oState;
    logic        oStepTick;
    logic        oFireReq;
    logic [15:0] oScore;
    logic [1:0]  oLives;
    logic [5:0]  oAliensLeft;
    logic [3:0]  oWave;

    game_sequencer dut (
        .iCLK          (iCLK),
        .iRST_N        (iRST_N),
        .iStart_N      (iStart_N),
        .iFire_N       (iFire_N),
        .iPx           (iPx),
        .iPy           (iPy),
        .iAlienHit     (iAlienHit),
        .iPlayerHit    (iPlayerHit),
        .iAliensLanded (iAliensLanded),
        .iBulletBusy   (iBulletBusy),
        .oState        (oState),
        .oStepTick     (oStepTick),
        .oFireReq      (oFireReq),
        .oScore        (oScore),
        .oLives        (oLives),
        .oAliensLeft   (oAliensLeft),
        .oWave         (oWave)
    );

    always #5 iCLK = ~iCLK;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   step_cnt  = 0;
    int   fire_cnt  = 0;
    int   pulse_err = 0;
    logic prev_step = 1'b0;
    logic prev_fire = 1'b0;

    // Pulse counters, sampled mid-cycle. A pulse held for two cycles is an error.
    always @(negedge iCLK) begin
        if (oStepTick) step_cnt++;
        if (oFireReq)  fire_cnt++;
        if (oStepTick && prev_step) pulse_err++;
        if (oFireReq && prev_fire)  pulse_err++;
        prev_step = oStepTick;
        prev_fire = oFireReq;
    end

    typedef struct {
        logic       alien_hit;
        logic       player_hit;
        logic       landed;
        logic [1:0] exp_state;
        logic [1:0] exp_lives;
        logic [5:0] exp_aliens;
        logic [15:0] exp_score;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick_clk(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic frame_tick(input int hold);
        iPx = 10'd0;
        iPy = 10'd480;
        tick_clk(hold);
        iPx = 10'd1;
        iPy = 10'd0;
        tick_clk(1);
    endtask

    task automatic hit_aliens(input int n);
        for (int i = 0; i < n; i++) begin
            iAlienHit = 1'b1;
            tick_clk(1);
            iAlienHit = 1'b0;
            tick_clk(1);
        end
    endtask

    task automatic hit_player(input int n);
        for (int i = 0; i < n; i++) begin
            iPlayerHit = 1'b1;
            tick_clk(1);
            iPlayerHit = 1'b0;
            tick_clk(1);
        end
    endtask

    task automatic press_fire();
        iFire_N = 1'b0;
        tick_clk(4);
        iFire_N = 1'b1;
        tick_clk(4);
    endtask

    task automatic start_game();
        int cyc;
        cyc = 0;
        iStart_N = 1'b0;
        while (oState != 2'd1 && cyc < 8) begin
            tick_clk(1);
            cyc++;
        end
        chk("start_state", {30'd0, oState}, 32'd1);
        chk("start_latency_le3", {31'd0, (cyc <= 3)}, 32'd1);
        iStart_N = 1'b1;
        tick_clk(3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;

        // {alien_hit, player_hit, landed, state, lives, aliens, score}
        vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd1, 2'd3, 6'd39, 16'd10};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 2'd1, 2'd2, 6'd39, 16'd10};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 2'd1, 2'd1, 6'd38, 16'd20};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 6'd38, 16'd20};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 6'd37, 16'd30};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 6'd37, 16'd30};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 6'd37, 16'd30};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 6'd37, 16'd30};

        iRST_N = 1'b0;
        iStart_N = 1'b1;
        iFire_N = 1'b1;
        iPx = 10'd1;
        iPy = 10'd0;
        iAlienHit = 1'b0;
        iPlayerHit = 1'b0;
        iAliensLanded = 1'b0;
        iBulletBusy = 1'b0;
        tick_clk(3);

        // Reset values
        chk("rst_state",  {30'd0, oState}, 32'd0);
        chk("rst_step",   {31'd0, oStepTick}, 32'd0);
        chk("rst_fire",   {31'd0, oFireReq}, 32'd0);
        chk("rst_score",  {16'd0, oScore}, 32'd0);
        chk("rst_lives",  {30'd0, oLives}, 32'd3);
        chk("rst_aliens", {26'd0, oAliensLeft}, 32'd40);
        chk("rst_wave",   {28'd0, oWave}, 32'd1);
        iRST_N = 1'b1;
        tick_clk(3);
        chk("idle_no_spurious_start", {30'd0, oState}, 32'd0);

        // Start a game
        start_game();
        chk("start_lives",  {30'd0, oLives}, 32'd3);
        chk("start_aliens", {26'd0, oAliensLeft}, 32'd40);
        chk("start_wave",   {28'd0, oWave}, 32'd1);
        chk("start_score",  {16'd0, oScore}, 32'd0);

        // Step pacing: 40 aliens -> divider 22. Some ticks dwell several cycles.
        base = step_cnt;
        for (int i = 0; i < 66; i++) frame_tick((i % 3) + 1);
        tick_clk(3);
        chk("steps_div22_66ticks", step_cnt - base, 32'd3);

        // 38 hits -> 2 aliens left, divider 3
        hit_aliens(38);
        chk("aliens_after_38", {26'd0, oAliensLeft}, 32'd2);
        chk("score_after_38",  {16'd0, oScore}, 32'd380);
        base = step_cnt;
        for (int i = 0; i < 6; i++) frame_tick(1);
        tick_clk(3);
        chk("steps_div3_6ticks", step_cnt - base, 32'd2);

        // Fire press while busy is dropped; press while idle fires once
        iBulletBusy = 1'b1;
        base = fire_cnt;
        press_fire();
        tick_clk(2);
        chk("fire_busy_dropped", fire_cnt - base, 32'd0);
        iBulletBusy = 1'b0;
        tick_clk(2);
        base = fire_cnt;
        press_fire();
        tick_clk(2);
        chk("fire_idle_single", fire_cnt - base, 32'd1);

        // Held fire, bullet ends three times
        iBulletBusy = 1'b1;
        tick_clk(2);
        base = fire_cnt;
        iFire_N = 1'b0;
        tick_clk(4);
        for (int i = 0; i < 3; i++) begin
            iBulletBusy = 1'b0;
            tick_clk(2);
            iBulletBusy = 1'b1;
            tick_clk(2);
        end
        iFire_N = 1'b1;
        tick_clk(4);
        iBulletBusy = 1'b0;
        tick_clk(2);
`ifdef GAME_SEQ_AUTOFIRE_EN
        chk("fire_held_autofire", fire_cnt - base, 32'd3);
`else
        chk("fire_held_no_autofire", fire_cnt - base, 32'd0);
`endif

        // Clear the wave: 40 hits total -> 400 points, then 60-frame pause
        hit_aliens(2);
        chk("clear_state", {30'd0, oState}, 32'd2);
        chk("clear_score", {16'd0, oScore}, 32'd400);
        base = step_cnt;
        for (int i = 0; i < 59; i++) frame_tick(1);
        chk("clear_hold_59", {30'd0, oState}, 32'd2);
        hit_player(1);
        chk("clear_hit_ignored", {30'd0, oLives}, 32'd3);
        frame_tick(1);
        tick_clk(1);
        chk("wave2_state",  {30'd0, oState}, 32'd1);
        chk("wave2_wave",   {28'd0, oWave}, 32'd2);
        chk("wave2_aliens", {26'd0, oAliensLeft}, 32'd40);
        chk("wave2_score",  {16'd0, oScore}, 32'd400);
        chk("clear_no_steps", step_cnt - base, 32'd0);

        // Last alien and last life in the same cycle -> OVER wins
        hit_aliens(39);
        hit_player(2);
        chk("pre_both_lives",  {30'd0, oLives}, 32'd1);
        chk("pre_both_aliens", {26'd0, oAliensLeft}, 32'd1);
        iAlienHit = 1'b1;
        iPlayerHit = 1'b1;
        tick_clk(1);
        iAlienHit = 1'b0;
        iPlayerHit = 1'b0;
        tick_clk(1);
        chk("both_state",  {30'd0, oState}, 32'd3);
        chk("both_lives",  {30'd0, oLives}, 32'd0);
        chk("both_score",  {16'd0, oScore}, 32'd800);
        chk("both_aliens", {26'd0, oAliensLeft}, 32'd0);
        tick_clk(3);
        chk("over_holds_score", {16'd0, oScore}, 32'd800);

        // Restart from OVER
        start_game();
        chk("restart_score",  {16'd0, oScore}, 32'd0);
        chk("restart_lives",  {30'd0, oLives}, 32'd3);
        chk("restart_wave",   {28'd0, oWave}, 32'd1);
        chk("restart_aliens", {26'd0, oAliensLeft}, 32'd40);

        // Table of hit vectors, applied one cycle each
        for (int i = 0; i < 8; i++) begin
            iAlienHit = vecs[i].alien_hit;
            iPlayerHit = vecs[i].player_hit;
            iAliensLanded = vecs[i].landed;
            tick_clk(1);
            iAlienHit = 1'b0;
            iPlayerHit = 1'b0;
            iAliensLanded = 1'b0;
            chk($sformatf("vec%0d_state", i),  {30'd0, oState}, {30'd0, vecs[i].exp_state});
            chk($sformatf("vec%0d_lives", i),  {30'd0, oLives}, {30'd0, vecs[i].exp_lives});
            chk($sformatf("vec%0d_aliens", i), {26'd0, oAliensLeft}, {26'd0, vecs[i].exp_aliens});
            chk($sformatf("vec%0d_score", i),  {16'd0, oScore}, vecs[i].exp_score);
        end

        // Mid-game reset on the cycle a step would otherwise be due
        start_game();
        for (int i = 0; i < 21; i++) frame_tick(1);
        base = step_cnt;
        iPx = 10'd0;
        iPy = 10'd480;
        iAlienHit = 1'b1;
        iRST_N = 1'b0;
        tick_clk(1);
        iRST_N = 1'b1;
        iAlienHit = 1'b0;
        iPx = 10'd1;
        iPy = 10'd0;
        chk("midrst_state", {30'd0, oState}, 32'd0);
        chk("midrst_step",  {31'd0, oStepTick}, 32'd0);
        chk("midrst_score", {16'd0, oScore}, 32'd0);
        tick_clk(1);
        chk("midrst_step_after", {31'd0, oStepTick}, 32'd0);
        tick_clk(3);
        chk("midrst_no_steps", step_cnt - base, 32'd0);
        chk("midrst_aliens", {26'd0, oAliensLeft}, 32'd40);

        chk("pulse_width", pulse_err, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
